// File: rtl/game_sequencer.sv
// Game-flow controller: cover -> countdown -> play <-> pause -> game-over -> cover.
// Drives the datapath reset/run enables, the screen select and a BCD high score.
module game_sequencer #(
    parameter int COUNT_START  = 3,
    parameter int COUNT_FRAMES = 60,
    parameter int OVER_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       enter_p,
    input  logic       pause_p,
    input  logic       slime_die,
    input  logic [3:0] score_1,
    input  logic [3:0] score_0,
    output logic [1:0] screen,
    output logic       game_rst,
    output logic       run,
    output logic       paused,
    output logic [1:0] countdown,
    output logic [3:0] hi_1,
    output logic [3:0] hi_0
);

    typedef enum logic [2:0] {
        COVER     = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } state_t;

    localparam logic [7:0] COUNT_LAST = 8'(COUNT_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
    localparam logic [1:0] COUNT_INIT = 2'(COUNT_START);

    state_t     state;
    state_t     next_state;
    logic [7:0] frame_cnt;
    logic [7:0] next_frame_cnt;
    logic [1:0] next_countdown;
    logic [7:0] next_hi;
    logic [1:0] next_screen;
    logic       next_run;
    logic       next_paused;
    logic       next_game_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COVER;
            frame_cnt <= 8'd0;
            countdown <= 2'd0;
            hi_1      <= 4'd0;
            hi_0      <= 4'd0;
            screen    <= 2'd0;
            run       <= 1'b0;
            paused    <= 1'b0;
            game_rst  <= 1'b1;
        end else begin
            state     <= next_state;
            frame_cnt <= next_frame_cnt;
            countdown <= next_countdown;
            hi_1      <= next_hi[7:4];
            hi_0      <= next_hi[3:0];
            screen    <= next_screen;
            run       <= next_run;
            paused    <= next_paused;
            game_rst  <= next_game_rst;
        end
    end

    // A frame tick coinciding with a transition is consumed by the old state;
    // the counter then restarts from zero in the new state.
    always_comb begin
        next_state     = state;
        next_frame_cnt = frame_tick ? frame_cnt + 8'd1 : frame_cnt;
        next_countdown = countdown;
        next_hi        = {hi_1, hi_0};
        case (state)
            COVER: begin
                if (enter_p) begin
                    next_state     = COUNTDOWN;
                    next_countdown = COUNT_INIT;
                end
            end
            COUNTDOWN: begin
                if (frame_tick && frame_cnt == COUNT_LAST) begin
                    next_frame_cnt = 8'd0;
                    next_countdown = countdown - 2'd1;
                    if (countdown == 2'd1) next_state = PLAY;
                end
            end
            PLAY: begin
                if (slime_die) begin
                    next_state = OVER;
                    if ({score_1, score_0} > {hi_1, hi_0}) next_hi = {score_1, score_0};
                end else if (pause_p) begin
                    next_state = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_p || enter_p) next_state = PLAY;
            end
            OVER: begin
                if (frame_tick && frame_cnt == OVER_LAST) next_state = COVER;
            end
            default: begin
                next_state     = COVER;
                next_countdown = 2'd0;
            end
        endcase
        if (next_state != state) next_frame_cnt = 8'd0;
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        next_screen   = 2'd1;
        next_run      = 1'b0;
        next_paused   = 1'b0;
        next_game_rst = (state == COVER) && (next_state == COUNTDOWN);
        case (next_state)
            COVER: next_screen = 2'd0;
            PLAY:  next_run    = 1'b1;
            PAUSE: next_paused = 1'b1;
            OVER:  next_screen = 2'd2;
            default: next_screen = 2'd1;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed game scenarios followed by random play,
// every cycle compared against a behavioural model of the game flow.
module tb_game_sequencer;

    localparam int CS = 3;
    localparam int CF = 2;
    localparam int OF = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       enter_p;
    logic       pause_p;
    logic       slime_die;
    logic [3:0] score_1;
    logic [3:0] score_0;
    logic [1:0] screen;
    logic       game_rst;
    logic       run;
    logic       paused;
    logic [1:0] countdown;
    logic [3:0] hi_1;
    logic [3:0] hi_0;

    int compared   = 0;
    int mismatched = 0;

    // Model: mode 0 cover, 1 countdown, 2 play, 3 pause, 4 game-over.
    int mMode   = 0;
    int mFrames = 0;
    int mDigit  = 0;
    int mHi     = 0;
    int mGrst   = 1;

    game_sequencer #(
        .COUNT_START (CS),
        .COUNT_FRAMES(CF),
        .OVER_FRAMES (OF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .enter_p   (enter_p),
        .pause_p   (pause_p),
        .slime_die (slime_die),
        .score_1   (score_1),
        .score_0   (score_0),
        .screen    (screen),
        .game_rst  (game_rst),
        .run       (run),
        .paused    (paused),
        .countdown (countdown),
        .hi_1      (hi_1),
        .hi_0      (hi_0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void enterMode(input int m);
        mMode   = m;
        mFrames = 0;
    endfunction

    function automatic void modelStep();
        int score;
        score = int'({score_1, score_0});
        if (rst) begin
            mMode = 0; mFrames = 0; mDigit = 0; mHi = 0; mGrst = 1;
            return;
        end
        mGrst = 0;
        case (mMode)
            0: begin
                if (enter_p) begin
                    enterMode(1);
                    mDigit = CS;
                    mGrst  = 1;
                end else if (frame_tick) mFrames = (mFrames + 1) % 256;
            end
            1: begin
                if (frame_tick) begin
                    if (mFrames == CF - 1) begin
                        mFrames = 0;
                        mDigit  = mDigit - 1;
                        if (mDigit == 0) enterMode(2);
                    end else mFrames = mFrames + 1;
                end
            end
            2: begin
                if (slime_die) begin
                    if (score > mHi) mHi = score;
                    enterMode(4);
                end else if (pause_p) enterMode(3);
                else if (frame_tick) mFrames = (mFrames + 1) % 256;
            end
            3: begin
                if (pause_p || enter_p) enterMode(2);
                else if (frame_tick) mFrames = (mFrames + 1) % 256;
            end
            default: begin
                if (frame_tick) begin
                    if (mFrames == OF - 1) enterMode(0);
                    else mFrames = mFrames + 1;
                end
            end
        endcase
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic applyStimulus(input logic r, input logic t, input logic e,
                                 input logic p, input logic d);
        rst = r; frame_tick = t; enter_p = e; pause_p = p; slime_die = d;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("screen", int'(screen), (mMode == 0) ? 0 : (mMode == 4) ? 2 : 1);
        checkOutput("run", int'(run), (mMode == 2) ? 1 : 0);
        checkOutput("paused", int'(paused), (mMode == 3) ? 1 : 0);
        checkOutput("countdown", int'(countdown), mDigit);
        checkOutput("game_rst", int'(game_rst), mGrst);
        checkOutput("hi", int'({hi_1, hi_0}), mHi);
    endtask

    task automatic setScore(input logic [7:0] s);
        score_1 = s[7:4];
        score_0 = s[3:0];
    endtask

    task automatic startToPlay();
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 2 * CS; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("play_after_count", int'(run), 1);
    endtask

    task automatic finishOver();
        for (int i = 0; i < OF; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("over_to_cover", int'(screen), 0);
    endtask

    initial begin
        logic die;
        setScore(8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("grst_after_release", int'(game_rst), 1);
        checkOutput("hi_reset", int'({hi_1, hi_0}), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("grst_drop", int'(game_rst), 0);

        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("enter_wins_cd", int'(countdown), 3);
        checkOutput("enter_grst", int'(game_rst), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("grst_one_cycle", int'(game_rst), 0);

        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            if (i == 6) begin
                checkOutput("play_run", int'(run), 1);
                checkOutput("play_cd0", int'(countdown), 0);
            end
            applyStimulus(0, 0, 0, 0, 0);
        end

        setScore(8'h19);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("pause_on", int'(paused), 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("pause_ignores_die", int'(screen), 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("resume_run", int'(run), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("die_over", int'(screen), 2);
        checkOutput("hi_19", int'({hi_1, hi_0}), 8'h19);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("over_holds", int'(screen), 2);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("over_done", int'(screen), 0);

        startToPlay();
        setScore(8'h27);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("hi_27", int'({hi_1, hi_0}), 8'h27);
        finishOver();

        startToPlay();
        setScore(8'h15);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("hi_keeps_27", int'({hi_1, hi_0}), 8'h27);
        finishOver();

        startToPlay();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_mid_play_run", int'(run), 0);
        checkOutput("rst_clears_hi", int'({hi_1, hi_0}), 0);

        die = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) die = ~die;
            score_1 = 4'($urandom_range(0, 9));
            score_0 = 4'($urandom_range(0, 9));
            applyStimulus(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          die);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
